// File: rtl/vita49_packetizer.sv
// VITA-49 IF Data packet builder (with Stream ID, sample-count timestamp).
// Buffers incoming 32-bit I/Q samples in a first-word-fall-through FIFO. Each
// packet is emitted as 32-bit words over a valid/ready handshake:
// header, stream ID, timestamp high, timestamp low, then PAYLOAD_WORDS samples.
//
// Ports:
//   sys_clk, reset       clock, synchronous active-high reset
//   enable               accept samples and allow new packets to start
//   sample_data/valid    input samples, no backpressure
//   word_ready           downstream accepts word_data
//   word_data/valid      packet word stream
//   word_sop/eop         first (header) / last (payload) word markers
//   fifo_level           current sample FIFO occupancy
//   overflow             sticky: a sample was dropped because the FIFO was full
module vita49_packetizer #(
  parameter int unsigned PAYLOAD_WORDS = 16,
  parameter int unsigned FIFO_DEPTH    = 32,
  parameter logic [31:0] STREAM_ID     = 32'h0000_0001
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [31:0]                   sample_data,
  input  logic                          sample_valid,
  input  logic                          word_ready,
  output logic [31:0]                   word_data,
  output logic                          word_valid,
  output logic                          word_sop,
  output logic                          word_eop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = AW + 1;

  localparam logic [15:0]     PktLen  = 16'(PAYLOAD_WORDS + 4);
  localparam logic [15:0]     PayLast = 16'(PAYLOAD_WORDS - 1);
  localparam logic [LvlW-1:0] PayLvl  = LvlW'(PAYLOAD_WORDS);
  localparam logic [LvlW-1:0] FullLvl = LvlW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StHdr, StSid, StTsh, StTsl, StPay} state_e;

  state_e state_q, state_d;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [63:0]     sample_cnt_q;
  logic [63:0]     ts_q;
  logic [3:0]      pkt_cnt_q;
  logic [15:0]     pay_cnt_q;
  logic            overflow_q;

  logic full, pop, push, drop, pay_last;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign full       = (fifo_level == FullLvl);
  assign pay_last   = (pay_cnt_q == PayLast);
  assign pop        = (state_q == StPay) && word_ready;
  // When full, a simultaneous pop frees the slot being written.
  assign push       = sample_valid && enable && (!full || pop);
  assign drop       = sample_valid && enable && full && !pop;
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    word_valid = 1'b0;
    word_sop   = 1'b0;
    word_eop   = 1'b0;
    word_data  = 32'h0;
    case (state_q)
      StIdle: begin
        // Wait for a full payload so the packet never starves mid-stream.
        if (enable && (fifo_level >= PayLvl)) state_d = StHdr;
      end
      StHdr: begin
        word_valid = 1'b1;
        word_sop   = 1'b1;
        word_data  = {4'b0001, 4'b0000, 4'b0001, pkt_cnt_q, PktLen};
        if (word_ready) state_d = StSid;
      end
      StSid: begin
        word_valid = 1'b1;
        word_data  = STREAM_ID;
        if (word_ready) state_d = StTsh;
      end
      StTsh: begin
        word_valid = 1'b1;
        word_data  = ts_q[63:32];
        if (word_ready) state_d = StTsl;
      end
      StTsl: begin
        word_valid = 1'b1;
        word_data  = ts_q[31:0];
        if (word_ready) state_d = StPay;
      end
      StPay: begin
        word_valid = 1'b1;
        word_eop   = pay_last;
        word_data  = mem[rd_ptr_q[AW-1:0]];
        if (word_ready && pay_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= sample_data;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sample_cnt_q <= '0;
      ts_q         <= '0;
      pkt_cnt_q    <= '0;
      pay_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + 1'b1;
        sample_cnt_q <= sample_cnt_q + 64'd1;
      end
      if (state_q == StIdle && state_d == StHdr) ts_q <= sample_cnt_q;
      if (state_q != StPay) begin
        pay_cnt_q <= '0;
      end else if (pop) begin
        pay_cnt_q <= pay_last ? 16'd0 : pay_cnt_q + 16'd1;
      end
      if (pop && pay_last) pkt_cnt_q <= pkt_cnt_q + 4'd1;
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule
